cdb_arbiter: RTL
================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter: TAG_W, 8, reservation-station tag width.
REQ-002 Parameter: DATA_W, 32, result data width; bus width BW = TAG_W+DATA_W (40 at defaults).
REQ-003 Parameter: CNT_W, 16, width of each statistics counter.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 add_req / mult_req / load_req  in  1 each  requester has a result pending.
REQ-007 add_res / mult_res / load_res  in  BW each  {tag, data} offered by each unit; held stable while its req is high and ungranted.
REQ-008 stall  in  1  completion stage stalled; no grants while high.
REQ-009 flush  in  1  one-cycle pulse; abandon pending traffic after exception recovery.
REQ-010 add_gnt / mult_gnt / load_gnt  out  1 each  combinational grant; req&gnt at a posedge = transfer.
REQ-011 cdb  out  BW  registered common data bus {tag, data}.
REQ-012 cdb_valid  out  1  cdb carries a new result this cycle.
REQ-013 exc  out  1  sticky: an all-ones result was broadcast; cleared by flush.
REQ-014 add_cnt / mult_cnt / load_cnt  out  CNT_W each  grant counters (present only with CDB_STATS_EN).

Function
REQ-015 At most one gnt high per cycle; gnt only to a requester with req high, tag nonzero, FSM in RUN, stall low, flush low.
REQ-016 Round-robin order add(0) -> mult(1) -> load(2); search starts at pointer ptr, wraps 2 -> 0.
REQ-017 On transfer, ptr <= winner+1 modulo 3; no transfer -> ptr unchanged.
REQ-018 Latency one cycle: transfer at posedge N -> cdb = winner's res and cdb_valid = 1 during cycle N+1.
REQ-019 No transfer at a posedge -> cdb_valid <= 0, cdb holds last value.
REQ-020 Request with tag 8'h00 is never granted; it stalls only that requester.
REQ-021 Back-to-back: same requester may win consecutive cycles only if no other eligible requester exists.
REQ-022 FSM states RUN, EXC, FLUSH; reset state RUN.
REQ-023 RUN -> EXC when transferred data == all-ones (DATA_W bits); that result is still broadcast and exc <= 1.
REQ-024 EXC: no grants, cdb_valid 0; exits only on flush.
REQ-025 flush in any state -> FLUSH for exactly one cycle: no grants, cdb_valid <= 0, ptr <= 0, exc <= 0; then RUN.
REQ-026 flush and a would-be transfer in same cycle: flush wins, no transfer.
REQ-027 stall high in RUN: no grants, state and ptr unchanged; grants resume the cycle stall drops.

Reset
REQ-028 rst high at a posedge: state RUN, ptr 0, cdb 0, cdb_valid 0, exc 0, counters 0; gnts 0 while rst high.
REQ-029 rst overrides flush, stall and any pending transfer, mid-operation included.

Configuration
REQ-030 Macro CDB_STATS_EN defined: add_cnt/mult_cnt/load_cnt present, each +1 per own transfer, saturating at all-ones, not cleared by flush.
REQ-031 CDB_STATS_EN undefined: counter ports and logic absent; all other behaviour identical.

Structure
REQ-032 Package cdb_pkg holds: tag constants A0,A1,A2,M0,M1,LD0,LD1, R0..R3, requester index enum, FSM state enum, EXC_DATA all-ones constant.
REQ-033 Sub-module cdb_rr_picker: combinational 3-way round-robin picker (eligible vector, ptr -> one-hot winner).

Verification
REQ-034 Reset, then add_req=1, add_res={A0,32'h5}, others idle -> add_gnt=1 at once; next cycle cdb={A0,32'h5}, cdb_valid=1.
REQ-035 All three req held 6 cycles from ptr 0 -> grant order add,mult,load,add,mult,load; cdb_valid=1 every cycle after the first.
REQ-036 mult_res={M1,32'hFFFFFFFF} granted -> broadcast next cycle, exc=1; add_req held 5 cycles -> no grant; flush -> one idle cycle, exc=0, add granted the cycle after.
REQ-037 stall=1 for 3 cycles with load_req=1 -> load_gnt=0, cdb_valid=0; stall drops -> load_gnt=1 same cycle.
REQ-038 load_req=1 with tag 8'h00 and mult_req=1 -> only mult granted; rst asserted mid-burst -> all outputs at reset values next cycle.
REQ-039 CDB_STATS_EN defined: 70000 add transfers -> add_cnt=16'hFFFF.

Source files
------------

// File: rtl/cdb_pkg.sv
// rtl/cdb_pkg.sv - shared constants and types for the common data bus arbiter
//
// Purpose: reservation-station tag constants, requester index and FSM state
//          enums, and the all-ones exception data pattern.
// Ports:   none (package).

package cdb_pkg;

  // Reservation-station tags. Tag 8'h00 means "no producer" and is never granted.
  localparam logic [7:0] TAG_NONE = 8'h00;
  localparam logic [7:0] A0       = 8'h01;
  localparam logic [7:0] A1       = 8'h02;
  localparam logic [7:0] A2       = 8'h03;
  localparam logic [7:0] M0       = 8'h04;
  localparam logic [7:0] M1       = 8'h05;
  localparam logic [7:0] LD0      = 8'h06;
  localparam logic [7:0] LD1      = 8'h07;
  localparam logic [7:0] R0       = 8'h08;
  localparam logic [7:0] R1       = 8'h09;
  localparam logic [7:0] R2       = 8'h0A;
  localparam logic [7:0] R3       = 8'h0B;

  // Result pattern that signals an exception when it is broadcast.
  localparam logic [31:0] EXC_DATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    REQ_ADD  = 2'd0,
    REQ_MULT = 2'd1,
    REQ_LOAD = 2'd2
  } req_idx_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_EXC   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Round-robin successor, wrapping load back to add.
  function automatic req_idx_e next_idx(input req_idx_e idx);
    case (idx)
      REQ_ADD:  next_idx = REQ_MULT;
      REQ_MULT: next_idx = REQ_LOAD;
      default:  next_idx = REQ_ADD;
    endcase
  endfunction

endpackage

// File: rtl/cdb_rr_picker.sv
// rtl/cdb_rr_picker.sv - combinational 3-way round-robin picker
//
// Purpose: choose the first eligible requester starting at ptr, wrapping 2 -> 0.
// Ports:
//   elig [2:0]  in   eligible requesters (bit 0 add, 1 mult, 2 load)
//   ptr  [1:0]  in   index searched first (3 is treated as 0)
//   win  [2:0]  out  one-hot winner, zero when nothing is eligible

module cdb_rr_picker (
  input  logic [2:0] elig,
  input  logic [1:0] ptr,
  output logic [2:0] win
);

  logic [2:0] rot;
  logic [2:0] pick;

  always_comb begin
    // Rotate so that bit 0 is the requester at ptr, pick the lowest set bit,
    // then rotate the one-hot result back into requester order.
    rot  = elig;
    win  = 3'b000;
    case (ptr)
      2'd1:    rot = {elig[0], elig[2], elig[1]};
      2'd2:    rot = {elig[1], elig[0], elig[2]};
      default: rot = elig;
    endcase

    if (rot[0])      pick = 3'b001;
    else if (rot[1]) pick = 3'b010;
    else if (rot[2]) pick = 3'b100;
    else             pick = 3'b000;

    case (ptr)
      2'd1:    win = {pick[1], pick[0], pick[2]};
      2'd2:    win = {pick[0], pick[2], pick[1]};
      default: win = pick;
    endcase
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin common data bus arbiter with exception/flush FSM
//
// Purpose: grants one of add/mult/load per cycle onto a registered CDB, stops
//          granting after an all-ones result until flushed. Optional grant
//          counters are built when the macro CDB_STATS_EN is defined.
// Ports:
//   clk, rst                    in   clock, synchronous active-high reset
//   add/mult/load_req           in   requester has a result pending
//   add/mult/load_res [BW-1:0]  in   {tag, data} offered by each unit
//   stall, flush                in   completion stall, recovery flush pulse
//   add/mult/load_gnt           out  combinational grant
//   cdb [BW-1:0], cdb_valid     out  registered bus and its valid
//   exc                         out  sticky exception flag
//   add/mult/load_cnt [CNT_W-1:0] out grant counters (CDB_STATS_EN only)

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter  int TAG_W  = 8,
  parameter  int DATA_W = 32,
  parameter  int CNT_W  = 16,
  localparam int BW     = TAG_W + DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          add_req,
  input  logic          mult_req,
  input  logic          load_req,
  input  logic [BW-1:0] add_res,
  input  logic [BW-1:0] mult_res,
  input  logic [BW-1:0] load_res,
  input  logic          stall,
  input  logic          flush,
  output logic          add_gnt,
  output logic          mult_gnt,
  output logic          load_gnt,
  output logic [BW-1:0] cdb,
  output logic          cdb_valid,
  output logic          exc
`ifdef CDB_STATS_EN
  ,
  output logic [CNT_W-1:0] add_cnt,
  output logic [CNT_W-1:0] mult_cnt,
  output logic [CNT_W-1:0] load_cnt
`endif
);

  state_e        state_q, state_d;
  req_idx_e      ptr_q, ptr_d;
  logic [BW-1:0] cdb_q, cdb_d;
  logic          cdb_valid_q, cdb_valid_d;
  logic          exc_q, exc_d;

  logic [2:0]    elig;
  logic [2:0]    win_oh;
  logic [2:0]    gnt;
  logic          grant_en;
  req_idx_e      win_idx;
  logic [BW-1:0] win_res;

  // A zero tag has no consumer, so it only blocks its own requester.
  assign elig[0] = add_req  && (add_res[BW-1 -: TAG_W]  != '0);
  assign elig[1] = mult_req && (mult_res[BW-1 -: TAG_W] != '0);
  assign elig[2] = load_req && (load_res[BW-1 -: TAG_W] != '0);

  cdb_rr_picker u_picker (
    .elig (elig),
    .ptr  (ptr_q),
    .win  (win_oh)
  );

  assign grant_en = (state_q == ST_RUN) && !stall && !flush && !rst;
  assign gnt      = grant_en ? win_oh : 3'b000;

  assign add_gnt  = gnt[0];
  assign mult_gnt = gnt[1];
  assign load_gnt = gnt[2];

  always_comb begin
    win_idx = REQ_ADD;
    if (win_oh[1]) win_idx = REQ_MULT;
    if (win_oh[2]) win_idx = REQ_LOAD;
  end

  always_comb begin
    case (win_idx)
      REQ_MULT: win_res = mult_res;
      REQ_LOAD: win_res = load_res;
      default:  win_res = add_res;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cdb_d       = cdb_q;
    cdb_valid_d = 1'b0;
    exc_d       = exc_q;

    if (flush) begin
      state_d = ST_FLUSH;
      ptr_d   = REQ_ADD;
      exc_d   = 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (|gnt) begin
            cdb_d       = win_res;
            cdb_valid_d = 1'b1;
            ptr_d       = next_idx(win_idx);
            // The exception result is still broadcast; only later grants stop.
            if (win_res[DATA_W-1:0] == {DATA_W{1'b1}}) begin
              state_d = ST_EXC;
              exc_d   = 1'b1;
            end
          end
        end
        ST_EXC:   state_d = ST_EXC;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      ptr_q       <= REQ_ADD;
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      exc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cdb_q       <= cdb_d;
      cdb_valid_q <= cdb_valid_d;
      exc_q       <= exc_d;
    end
  end

  assign cdb       = cdb_q;
  assign cdb_valid = cdb_valid_q;
  assign exc       = exc_q;

`ifdef CDB_STATS_EN
  logic [CNT_W-1:0] add_cnt_q, add_cnt_d;
  logic [CNT_W-1:0] mult_cnt_q, mult_cnt_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;

  // Saturating per-requester grant counters; flush leaves them alone.
  always_comb begin
    add_cnt_d  = add_cnt_q;
    mult_cnt_d = mult_cnt_q;
    load_cnt_d = load_cnt_q;
    if (gnt[0] && (add_cnt_q  != '1)) add_cnt_d  = add_cnt_q  + 1'b1;
    if (gnt[1] && (mult_cnt_q != '1)) mult_cnt_d = mult_cnt_q + 1'b1;
    if (gnt[2] && (load_cnt_q != '1)) load_cnt_d = load_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      add_cnt_q  <= '0;
      mult_cnt_q <= '0;
      load_cnt_q <= '0;
    end else begin
      add_cnt_q  <= add_cnt_d;
      mult_cnt_q <= mult_cnt_d;
      load_cnt_q <= load_cnt_d;
    end
  end

  assign add_cnt  = add_cnt_q;
  assign mult_cnt = mult_cnt_q;
  assign load_cnt = load_cnt_q;
`else
  // Counter width only shapes the optional statistics ports; nothing to build.
  if (CNT_W < 1) begin : g_no_stats
  end
`endif

endmodule
